// File: rtl/bcd_counter_display_mux.sv
// bcd_counter_display_mux: divided-tick BCD up/down counter with muxed active-low 7-seg drive; define LEADING_ZERO_BLANK_EN to blank leading zeros
module bcd_counter_display_mux #(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIGITS  = 4,
  parameter int MUX_DIV = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry,
  output logic [6:0]            display,
  output logic [DIGITS-1:0]     digit_sel
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int MW = MUX_DIV > 1 ? $clog2(MUX_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0]       pre;
  logic [MW-1:0]       mux_cnt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                upd, mux_end;
  logic [4*DIGITS-1:0] clamped, stepped;
  logic [3:0]          d, nib;
  logic                hit, ripple, lead, blank_sel;
  logic [DIGITS-1:0]   blank;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign upd     = pre == PW'(CLK_DIV - 1);
  assign mux_end = mux_cnt == MW'(MUX_DIV - 1);
  assign idx_nxt = mux_end ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;

  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++)
      clamped[4*i +: 4] = load_val[4*i +: 4] > 4'd9 ? 4'd9 : load_val[4*i +: 4];
  end

  // ripple stops at the first digit that does not wrap; ripple out of the top digit is the wrap
  always_comb begin
    stepped = count;
    ripple  = 1'b1;
    d       = '0;
    hit     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d   = count[4*i +: 4];
      hit = up_dn ? d == 4'd9 : d == 4'd0;
      if (ripple) stepped[4*i +: 4] = hit ? (up_dn ? 4'd0 : 4'd9) : (up_dn ? d + 4'd1 : d - 4'd1);
      ripple = ripple & hit;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lead     = lead & (count[4*k +: 4] == 4'd0);
      blank[k] = lead;
    end
  end
`else
  assign blank = '0;
  assign lead  = 1'b0;
`endif

  always_comb begin
    nib       = '0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_nxt == IW'(i)) begin
        nib       = count[4*i +: 4];
        blank_sel = blank[i];
      end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pre       <= '0;
      tick      <= 1'b0;
      carry     <= 1'b0;
      count     <= '0;
      mux_cnt   <= '0;
      idx       <= '0;
      digit_sel <= ~DIGITS'(1);
      display   <= 7'b1000000;
    end else begin
      pre       <= upd ? '0 : pre + 1'b1;
      tick      <= upd;
      count     <= load ? clamped : (upd && en) ? stepped : count;
      carry     <= !load && upd && en && ripple;
      mux_cnt   <= mux_end ? '0 : mux_cnt + 1'b1;
      idx       <= idx_nxt;
      digit_sel <= ~(DIGITS'(1) << idx_nxt);
      display   <= blank_sel ? 7'b1111111 : seg(nib);
    end
endmodule

// File: tb/tb_bcd_counter_display_mux.sv
// tb_bcd_counter_display_mux: scoreboard bench, CLK_DIV=4 DIGITS=2 MUX_DIV=2
module tb_bcd_counter_display_mux;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00, count;
  logic       tick, carry;
  logic [6:0] display;
  logic [1:0] digit_sel;
  int         checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_GLYPH = 7'b1111111;
`else
  localparam logic [6:0] HI_GLYPH = 7'b1000000;
`endif

  bcd_counter_display_mux #(.CLK_DIV(4), .DIGITS(2), .MUX_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count), .tick(tick), .carry(carry), .display(display), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!tick && n < 32);
    chk("tick_seen", {31'd0, tick}, 1);
  endtask

  always @(negedge clk)
    if (rst) begin
      if (tick && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("tick_count", {24'd0, count}, {24'd0, mon_e[8:1]});
        chk("tick_carry", {31'd0, carry}, {31'd0, mon_e[0]});
      end
      if (!tick) chk("carry_outside_tick", {31'd0, carry}, 0);
    end

  initial begin
    int n;
    logic [1:0] s [8];
    repeat (2) @(negedge clk);
    chk("rst_count", {24'd0, count}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_carry", {31'd0, carry}, 0);
    chk("rst_digit_sel", {30'd0, digit_sel}, 2'b10);
    chk("rst_display", {25'd0, display}, 7'b1000000);
    en = 1'b1;
    up_dn = 1'b1;
    exp_q.push_back({8'h01, 1'b0});
    exp_q.push_back({8'h02, 1'b0});
    exp_q.push_back({8'h03, 1'b0});
    rst = 1'b1;
    wait_tick(n);
    chk("first_tick_edge", n, 4);
    wait_tick(n);
    chk("tick_period", n, 4);
    wait_tick(n);
    load = 1'b1;
    load_val = 8'h98;
    exp_q.push_back({8'h99, 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    @(negedge clk);
    load = 1'b0;
    chk("load_98", {24'd0, count}, 8'h98);
    wait_tick(n);
    wait_tick(n);
    load = 1'b1;
    load_val = 8'h00;
    up_dn = 1'b0;
    exp_q.push_back({8'h99, 1'b1});
    exp_q.push_back({8'h98, 1'b0});
    @(negedge clk);
    load = 1'b0;
    wait_tick(n);
    wait_tick(n);
    load = 1'b1;
    load_val = 8'hFA;
    @(negedge clk);
    load = 1'b0;
    chk("load_clamp", {24'd0, count}, 8'h99);
    @(negedge clk);
    @(negedge clk);
    load = 1'b1;
    load_val = 8'h42;
    exp_q.push_back({8'h42, 1'b0});
    wait_tick(n);
    chk("load_on_update_edge", n, 1);
    load_val = 8'h07;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s[i] = digit_sel;
      chk("mux_onehot", {31'd0, digit_sel == 2'b10 || digit_sel == 2'b01}, 1);
      chk("mux_display", {25'd0, display}, {25'd0, digit_sel == 2'b10 ? 7'b1111000 : HI_GLYPH});
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) chk("mux_alternate", {30'd0, s[i+2]}, {30'd0, ~s[i]});
    wait_tick(n);
    load = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("midrst_count", {24'd0, count}, 0);
    chk("midrst_tick", {31'd0, tick}, 0);
    chk("midrst_digit_sel", {30'd0, digit_sel}, 2'b10);
    chk("midrst_display", {25'd0, display}, 7'b1000000);
    up_dn = 1'b1;
    exp_q.push_back({8'h01, 1'b0});
    #2 rst = 1'b1;
    wait_tick(n);
    chk("first_tick_after_midrst", n, 4);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_counter_display_mux.md
Name: bcd_counter_display_mux

Overview:
Parametrised successor to the single-digit divided-clock counter.
- Divides the board clock into a count-enable tick.
- Runs a DIGITS-wide BCD up/down counter with synchronous load and wrap carry.
- Drives a time-multiplexed, active-low seven-segment bank through one shared segment bus and one-hot digit selects.
- Sits between the board clock/switches and the display pins of the lab top level.

Parameters:
- CLK_DIV, 50_000_000: clk cycles per count tick; must be >= 2.
- DIGITS, 4: number of BCD digits and display positions; must be >= 1.
- MUX_DIV, 50_000: clk cycles each digit is held on the segment bus; must be >= 1.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: asynchronous active-low reset.
- en, input, 1: count enable; sampled only on tick edges.
- up_dn, input, 1: 1 = count up, 0 = count down.
- load, input, 1: synchronous load strobe.
- load_val, input, 4*DIGITS: BCD load value; digit 0 is in bits [3:0].
- count, output, 4*DIGITS: current BCD value; digit 0 is in bits [3:0].
- tick, output, 1: one-cycle pulse marking a count-update edge.
- carry, output, 1: one-cycle pulse when the counter wrapped.
- display, output, 7: active-low segments ordered {g,f,e,d,c,b,a}.
- digit_sel, output, DIGITS: one-hot active-low digit enable.

Behaviour:
Reset (rst = 0, asynchronous, held):
- Prescaler 0, count 0, tick 0, carry 0.
- Mux counter 0, digit index 0.
- digit_sel = all ones except bit 0 = 0.
- display = 7'b1000000 (glyph "0").

Prescaler:
- Free-runs 0..CLK_DIV-1 and wraps; width is $clog2(CLK_DIV).
- The edge at which prescaler == CLK_DIV-1 is the "update edge".
- First update edge is the CLK_DIV-th rising edge after rst deasserts.

tick:
- Registered; high for exactly the one cycle following each update edge.
- Pulses regardless of en and load.

Count update (priority, highest first):
1. load = 1 at any edge: count <= load_val, carry <= 0.
   - Any load digit > 9 is clamped to 9.
   - Load overrides a coincident update edge; the prescaler is not disturbed.
2. Update edge with en = 1, up_dn = 1: BCD increment, ripple carry digit to digit.
   - All-nines wraps to all-zeros and sets carry <= 1.
3. Update edge with en = 1, up_dn = 0: BCD decrement with borrow.
   - All-zeros wraps to all-nines and sets carry <= 1.
4. Otherwise: count holds, carry <= 0.

carry:
- High only in the same cycle as tick, and only when that update wrapped.

Multiplexer:
- Mux counter runs 0..MUX_DIV-1, independent of the prescaler.
- At its terminal value the digit index advances, wrapping DIGITS-1 -> 0.
- digit_sel and display are both registered from the same digit index, so they change on the same edge; no cross-digit ghosting cycle.

Segment decode (active-low gfedcba):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Any other nibble = 1111111 (unreachable after clamping).

Mid-operation reset: all state returns to reset values immediately, with no clock needed. The first update edge after rst deasserts follows the first-update rule above.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit position k (k > 0) shows 1111111 when it and every higher digit are 0. Digit 0 is always shown. digit_sel timing is unchanged.
- Undefined: every digit shows its glyph, including leading zeros.

Test Plan:
All scenarios use CLK_DIV = 4, DIGITS = 2, MUX_DIV = 2.
1. Reset, then rst = 1, en = 1, up_dn = 1 -> tick after edges 4, 8, 12; count 00 -> 01 -> 02 -> 03; carry stays 0.
2. load = 1 with load_val = 8'h98 for one cycle, then count up -> count 98, 99, 00; carry = 1 only in the tick cycle where count becomes 00.
3. Load 8'h00, set up_dn = 0 -> next update gives count = 8'h99 with carry = 1; the following update gives 98 with carry = 0.
4. load_val = 8'hFA -> count = 8'h99 (clamped). Load asserted on an update edge -> count = load value, tick still pulses, carry = 0.
5. count = 8'h07, en = 1 -> digit_sel alternates 10/01 every 2 cycles; display = 1111000 while digit 0 is active, and 1000000 while digit 1 is active (1111111 if LEADING_ZERO_BLANK_EN is defined).
6. Drop rst for 3 ns mid-count (between clock edges) -> count = 00, tick = 0, digit_sel = 10 immediately; the first tick after release comes on the 4th edge.
